// File: rtl/led_walk_pkg.sv
// Shared widths, FSM state encoding and the one-hot helper for the LED walker.
package led_walk_pkg;

   localparam int LED_W = 8;
   localparam int POS_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WALK = 1'b1
   } state_e;

   // One-hot LED pattern for a position: bit pos lit, all others dark.
   function automatic logic [LED_W-1:0] onehot(input logic [POS_W-1:0] pos);
      return LED_W'(1) << pos;
   endfunction

endpackage : led_walk_pkg

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter that emits a single-cycle tick on its last
// count. clr restarts the count at zero so the next tick is a full DIV cycles
// away. DIV=1 degenerates to a tick on every cycle.
module tick_divider #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned        CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   // Next count: restart on clear or wrap, otherwise advance.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      if (clr || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_divider

// File: rtl/led_walk_decoder.sv
// Binary-to-one-hot LED driver. A 4-bit position request is accepted through a
// load/ready handshake; the single lit LED then walks one position every
// STEP_DIV cycles toward the target and holds there. Requests with bit 3 set
// are rejected with a one-cycle err pulse.
//
// Optional feature macro: LED_WALK_BLINK_EN
//   defined   - while idle the LED blinks (on/off every BLINK_DIV cycles,
//               starting with the on-phase on entry to idle); steady during a walk.
//   undefined - the LED is steady in every state and no blink counter exists.
module led_walk_decoder
   import led_walk_pkg::*;
#(
   parameter int unsigned STEP_DIV  = 25_000_000,
   parameter int unsigned BLINK_DIV = 12_500_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       bin_value,
   input  logic             load,
   output logic             ready,
   output logic             busy,
   output logic             err,
   output logic [LED_W-1:0] led
);

   // Both dividers must be at least one cycle long.
   if (STEP_DIV < 1 || BLINK_DIV < 1) begin : g_bad_div
      $error("led_walk_decoder: STEP_DIV and BLINK_DIV must be >= 1");
   end

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] target_q, target_d;
   logic             err_q, err_d;
   logic [LED_W-1:0] led_q, led_d;

   logic step_tick;
   logic step_clr;

   // The step counter only runs while walking; holding it clear in idle means
   // the accept edge leaves it at zero and the first step lands STEP_DIV later.
   assign step_clr = (state_q == ST_IDLE);

   tick_divider #(
      .DIV (STEP_DIV)
   ) u_step_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (step_clr),
      .tick (step_tick)
   );

   // Next-state, position and error-pulse logic for the idle/walk FSM.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      target_d = target_q;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               if (bin_value[POS_W]) begin
                  // Out-of-range request: flag it, leave position untouched.
                  err_d = 1'b1;
               end else if (bin_value[POS_W-1:0] != pos_q) begin
                  target_d = bin_value[POS_W-1:0];
                  state_d  = ST_WALK;
               end
               // Request for the current position is a silent no-op.
            end
         end

         ST_WALK: begin
            // load is deliberately ignored here; requests are not queued.
            if (step_tick) begin
               if (target_q > pos_q) begin
                  pos_d = pos_q + POS_W'(1);
               end else begin
                  pos_d = pos_q - POS_W'(1);
               end
               if (pos_d == target_q) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // LED pattern tracks the position on the same edge it moves.
      led_d = onehot(pos_d);
   end

   // FSM, position, target, LED and error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pos_q    <= '0;
         target_q <= '0;
         err_q    <= 1'b0;
         led_q    <= onehot('0);
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         target_q <= target_d;
         err_q    <= err_d;
         led_q    <= led_d;
      end
   end

   assign ready = (state_q == ST_IDLE);
   assign busy  = ~ready;
   assign err   = err_q;

`ifdef LED_WALK_BLINK_EN
   logic blink_tick;
   logic blink_clr;
   logic blink_on_q, blink_on_d;

   // Blink phase restarts from zero whenever a walk is in progress, so the
   // first on-phase after returning to idle is a full BLINK_DIV cycles.
   assign blink_clr = (state_q == ST_WALK);

   tick_divider #(
      .DIV (BLINK_DIV)
   ) u_blink_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (blink_clr),
      .tick (blink_tick)
   );

   // Forced on while walking (and on the accept edge); toggles on each blink tick in idle.
   always_comb begin
      blink_on_d = blink_on_q;
      if (state_q == ST_WALK || state_d == ST_WALK) begin
         blink_on_d = 1'b1;
      end else if (blink_tick) begin
         blink_on_d = ~blink_on_q;
      end
   end

   // Blink phase register.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_on_q <= 1'b1;
      end else begin
         blink_on_q <= blink_on_d;
      end
   end

   assign led = led_q & {LED_W{blink_on_q}};
`else
   assign led = led_q;
`endif

endmodule : led_walk_decoder
